modred_iter: RTL
================

// Module: modred_iter
// PURPOSE
//  Folded word-level Montgomery reducer for NTT-friendly primes q = qH*2^W + 1. Computes C = T * 2^(-W*ITER) mod q, fully reduced to [0,q).
//  Reuses one qH*T2 DSP multiplier for all ITER word steps, then applies a final conditional subtraction.
//  Valid/ready handshake on both sides. Sits after the butterfly multiplier in area-constrained NTT configurations.
//  Replaces an unrolled chain of single-word reduction stages.
// PARAMETERS
//  DATA_SIZE  `DATA_SIZE_ARB (64)     modulus width K; q < 2^K
//  W_SIZE     `W_SIZE (16)            word size W reduced per step; must divide DATA_SIZE
//  ITER       DATA_SIZE/W_SIZE        number of word steps; R = 2^(W*ITER)
// PORTS
//  clk        in   1             clock
//  reset      in   1             asynchronous, active-high reset
//  qH         in   K-W           q >> W; sampled on input handshake
//  in_valid   in   1             T/qH valid
//  in_ready   out  1             block idle, accepts input
//  T          in   2K            operand; caller guarantees T < q*R
//  out_valid  out  1             C valid
//  out_ready  in   1             consumer accepts C
//  C          out  K             result in [0,q)
// BEHAVIOUR
//  - Reset (async, any state): FSM -> IDLE; iteration count, internal T register, MULT, T2H, CARRY, C, out_valid cleared to 0.
//    in_ready = 1 while reset is held, because it is decoded from IDLE.
//  - in_ready = (state==IDLE), decoded combinationally. out_valid = (state==DONE), registered.
//  - Handshake: accept when in_valid & in_ready at a clk edge; T and qH are latched and the FSM moves to MUL.
//  - FSM: IDLE -> MUL -> ADD -> (MUL while cnt<ITER-1 | CORR when cnt==ITER-1) -> DONE -> IDLE when out_ready.
//  - MUL step, with TL = Treg[W-1:0]:
//      T2 = (-TL) mod 2^W
//      register MULT = qH*T2
//      register T2H = Treg >> W
//      register CARRY = (TL != 0)
//  - ADD step: Treg <= MULT + T2H + CARRY; cnt++.
//    Each step keeps Treg ≡ T*2^(-W*cnt) (mod q).
//  - Internal Treg width is 2K+1 bits. No intermediate value overflows when T < q*R.
//  - CORR: C <= (Treg >= q) ? Treg - q : Treg, where q = {qH,W'b1}. Treg < 2q is guaranteed.
//  - Latency: out_valid rises 2*ITER+1 cycles after the accept edge.
//    Minimum initiation interval is 2*ITER+2 cycles; no new input is accepted in the DONE cycle.
//  - Back-pressure: while out_valid & !out_ready, C and out_valid hold and in_ready stays 0.
//  - in_valid asserted outside IDLE is ignored and not queued.
//  - qH is read only at accept. Changes to qH mid-operation do not affect the result.
//  - Reset mid-operation aborts the operation with no output.
//    The first accept after release starts a fresh reduction, with cnt = 0.
//  - T >= q*R is out of contract; C is then unspecified but the handshake still completes.
// STRUCTURE
//  - Shared package/defines.v holds DATA_SIZE_ARB, W_SIZE and the FSM state localparams (IDLE, MUL, ADD, CORR, DONE).
//  - One sub-module, modred_iter_step: the MUL/ADD datapath with MULT tagged use_dsp. The parent owns the FSM, counter and correction.
// TESTING  (cfg DATA_SIZE=16, W_SIZE=8, ITER=2, qH=0x30, q=12289, R=65536)
//  - T=0 -> C=0, out_valid 5 cycles after accept.
//  - T=131072 (2R) -> C=2; T=12288*65536 -> C=12288.
//  - T=12289 (q) -> C=0, not q; this exercises the CORR path.
//  - out_ready=0 for 10 cycles after out_valid -> C and out_valid stable, in_ready=0.
//    Then out_ready=1 -> IDLE next cycle.
//  - Assert reset during the ADD of step 0 -> no out_valid.
//    Then T=65536 (R) is accepted -> C=1.
//  - Random T < q*R for 10k vectors, back-to-back in_valid, random out_ready -> C matches the model T*R^-1 mod q.
//    Random T and out_ready are drawn per transaction.

Source files
------------

// File: rtl/modred_iter_pkg.sv
// Shared constants and FSM state encoding for the folded word-level Montgomery reducer.
// Parameter defaults match the unrolled reducer that this block replaces.
package modred_iter_pkg;

  localparam int DATA_SIZE_ARB = 64;
  localparam int W_SIZE        = 16;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    ADD,
    CORR,
    DONE
  } state_e;

endpackage

// File: rtl/modred_iter_step.sv
// One Montgomery word step, reused on every iteration: a MUL phase registers qH*(-TL mod 2^W),
// then an ADD phase folds it back into the running value, which shrinks by one word per step.
module modred_iter_step #(
  parameter int K = 64,
  parameter int W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [2*K-1:0]   t_i,
  input  logic [K-W-1:0]   qh_i,
  input  logic             mul_i,
  input  logic             add_i,
  output logic [2*K:0]     treg_o
);

  localparam int TW = 2*K + 1;

  logic [TW-1:0]   treg_q;
  (* use_dsp = "yes" *) logic [K-1:0] mult_q;
  logic [TW-W-1:0] t2h_q;
  logic            carry_q;

  logic [W-1:0]    tl;
  logic [W-1:0]    t2;

  assign tl = treg_q[W-1:0];
  // The bottom word is cancelled exactly: TL + T2 is 0 or 2^W, and CARRY restores that 2^W after the shift.
  assign t2 = -tl;

  // NOTE: every register here is written with <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      treg_q  <= '0;
      mult_q  <= '0;
      t2h_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (load_i) begin
        treg_q <= {1'b0, t_i};
      end else if (add_i) begin
        treg_q <= TW'(mult_q) + TW'(t2h_q) + TW'(carry_q);
      end
      if (mul_i) begin
        mult_q  <= {{W{1'b0}}, qh_i} * {{(K-W){1'b0}}, t2};
        t2h_q   <= treg_q[TW-1:W];
        carry_q <= (tl != '0);
      end
    end
  end

  assign treg_o = treg_q;

endmodule

// File: rtl/modred_iter.sv
// Folded Montgomery reducer: C = T * 2^(-W*ITER) mod q, q = qH*2^W + 1, with valid/ready on both sides.
// The parent owns the FSM, step counter, qH capture and final conditional subtraction.
module modred_iter #(
  parameter int DATA_SIZE = modred_iter_pkg::DATA_SIZE_ARB,
  parameter int W_SIZE    = modred_iter_pkg::W_SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_SIZE-W_SIZE-1:0] qH,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*DATA_SIZE-1:0]      T,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_SIZE-1:0]        C
);

  import modred_iter_pkg::state_e;
  import modred_iter_pkg::IDLE;
  import modred_iter_pkg::MUL;
  import modred_iter_pkg::ADD;
  import modred_iter_pkg::CORR;
  import modred_iter_pkg::DONE;

  localparam int K    = DATA_SIZE;
  localparam int W    = W_SIZE;
  localparam int ITER = DATA_SIZE / W_SIZE;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int TW   = 2*K + 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [K-W-1:0] qh_q;
  logic [K-1:0]  c_q, c_d;
  logic          out_valid_q;

  logic          accept;
  logic          last_step;
  logic [TW-1:0] treg;
  logic [TW-1:0] q_ext;
  logic          treg_ge_q;

  assign in_ready  = (state_q == IDLE);
  assign accept    = in_valid & in_ready;
  assign last_step = (cnt_q == CW'(ITER - 1));

  modred_iter_step #(
    .K (K),
    .W (W)
  ) u_step (
    .clk    (clk),
    .rst    (reset),
    .load_i (accept),
    .t_i    (T),
    .qh_i   (qh_q),
    .mul_i  (state_q == MUL),
    .add_i  (state_q == ADD),
    .treg_o (treg)
  );

  // q is odd by construction, so its low word is always 1.
  assign q_ext     = TW'({qh_q, {(W-1){1'b0}}, 1'b1});
  assign treg_ge_q = (treg >= q_ext);

  // NOTE: each always_comb output gets a default first so no path can leave it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MUL;
          cnt_d   = '0;
        end
      end
      MUL:  state_d = ADD;
      ADD: begin
        if (last_step) begin
          state_d = CORR;
        end else begin
          state_d = MUL;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      CORR: begin
        state_d = DONE;
        c_d     = treg_ge_q ? K'(treg - q_ext) : K'(treg);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      qh_q        <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      c_q         <= c_d;
      out_valid_q <= (state_d == DONE);
      if (accept) qh_q <= qH;
    end
  end

  assign C         = c_q;
  assign out_valid = out_valid_q;

endmodule
